// File: rtl/cla_pkg.sv
// Shared types and constants for the 16-bit lookahead subtractor.
// Width is fixed by the slice geometry below.
package cla_pkg;

    localparam int SLICE_W  = 4;
    localparam int N_SLICES = 4;
    localparam int DATA_W   = SLICE_W * N_SLICES;
    localparam int HALF_W   = DATA_W / 2;

    typedef logic [SLICE_W-1:0] slice_t;

    typedef struct packed {
        logic borrow;
        logic zero;
        logic neg;
        logic ovf;
    } sub_flags_t;

endpackage

// File: rtl/cla4_sub_slice.sv
// One 4-bit carry-lookahead slice fed with a and inverted b.
// Exports group propagate/generate for the upper lookahead level.
module cla4_sub_slice
    import cla_pkg::*;
(
    input  slice_t a,
    input  slice_t b_inv,
    input  logic   cin,
    output slice_t s,
    output logic   P,
    output logic   G
);

    slice_t g;
    slice_t p;
    slice_t c;

    assign g = a & b_inv;
    assign p = a ^ b_inv;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;
    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla16_sub_pipe.sv
// Two-stage pipelined 16-bit subtractor (a - b) with compare flags.
// Define SUB_SATURATE_EN to clamp o to zero whenever a borrow occurs.
module cla16_sub_pipe
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o,
    output logic              borrow,
    output logic              zero,
    output logic              neg,
    output logic              ovf
);

    logic [DATA_W-1:0] b_inv;

    slice_t s0, s1, s2, s3;
    logic   P0, G0, P1, G1, P2, G2, P3, G3;
    logic   c4, c8_d, c12, c16;

    logic              s1_valid_q;
    logic [HALF_W-1:0] lo_q;
    logic              c8_q;
    logic [HALF_W-1:0] ahi_q;
    logic [HALF_W-1:0] bnhi_q;
    logic              a15_q;
    logic              b15_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] o_q;
    sub_flags_t        flags_q;

    logic              s1_adv;
    logic              s1_load;
    logic              s2_load;

    logic [DATA_W-1:0] raw_d;
    logic [DATA_W-1:0] o_d;
    sub_flags_t        flags_d;

    assign b_inv = ~b;

    // Stage 1: low byte, carry-in of 1 completes the two's complement
    cla4_sub_slice u_slice0 (
        .a     (a[3:0]),
        .b_inv (b_inv[3:0]),
        .cin   (1'b1),
        .s     (s0),
        .P     (P0),
        .G     (G0)
    );

    assign c4 = G0 | P0;

    cla4_sub_slice u_slice1 (
        .a     (a[7:4]),
        .b_inv (b_inv[7:4]),
        .cin   (c4),
        .s     (s1),
        .P     (P1),
        .G     (G1)
    );

    assign c8_d = G1 | (P1 & G0) | (P1 & P0);

    // Stage 2: high byte from registered operands and predicted c8
    cla4_sub_slice u_slice2 (
        .a     (ahi_q[3:0]),
        .b_inv (bnhi_q[3:0]),
        .cin   (c8_q),
        .s     (s2),
        .P     (P2),
        .G     (G2)
    );

    assign c12 = G2 | (P2 & c8_q);

    cla4_sub_slice u_slice3 (
        .a     (ahi_q[7:4]),
        .b_inv (bnhi_q[7:4]),
        .cin   (c12),
        .s     (s3),
        .P     (P3),
        .G     (G3)
    );

    assign c16 = G3 | (P3 & G2) | (P3 & P2 & c8_q);

    assign s1_adv  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign s1_load = in_valid && in_ready;
    assign s2_load = s1_valid_q && s1_adv;

    // Result assembly, optional clamp and flag derivation
    always_comb begin
        raw_d          = {s3, s2, lo_q};
        flags_d        = '0;
        flags_d.borrow = ~c16;
        flags_d.ovf    = (a15_q ^ b15_q) & (raw_d[DATA_W-1] ^ a15_q);
`ifdef SUB_SATURATE_EN
        o_d = flags_d.borrow ? '0 : raw_d;
`else
        o_d = raw_d;
`endif
        flags_d.zero = (o_d == '0);
        flags_d.neg  = o_d[DATA_W-1];
    end

    // Stage 1 registers: advance when downstream has room
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            c8_q       <= 1'b0;
            ahi_q      <= '0;
            bnhi_q     <= '0;
            a15_q      <= 1'b0;
            b15_q      <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (s1_load) begin
                lo_q   <= {s1, s0};
                c8_q   <= c8_d;
                ahi_q  <= a[DATA_W-1:HALF_W];
                bnhi_q <= b_inv[DATA_W-1:HALF_W];
                a15_q  <= a[DATA_W-1];
                b15_q  <= b[DATA_W-1];
            end
        end
    end

    // Stage 2 registers: hold result while consumer stalls
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s2_valid_q <= 1'b0;
            o_q        <= '0;
            flags_q    <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                o_q     <= o_d;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign o         = o_q;
    assign borrow    = flags_q.borrow;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign ovf       = flags_q.ovf;

endmodule
